// File: rtl/bbs_stream_gen_if.sv
// Configuration and output-stream bundle for bbs_stream_gen.
// The master side is the seed/key config plus the stream consumer; the slave side is the generator.
interface bbs_stream_gen_if #(
   parameter int M     = 16,
   parameter int OUT_W = 8
);
   logic             load;
   logic [M-1:0]     seed;
   logic [M-1:0]     n;
   logic [M-1:0]     c;
   logic             run;
   logic             out_ready;
   logic             out_valid;
   logic [OUT_W-1:0] out_data;
   logic             busy;
   logic             err;

   modport master (
      output load, seed, n, c, run, out_ready,
      input  out_valid, out_data, busy, err
   );

   modport slave (
      input  load, seed, n, c, run, out_ready,
      output out_valid, out_data, busy, err
   );
endinterface

// File: rtl/bbs_stream_gen.sv
// Blum-Blum-Shub stream generator: x <= x^2 mod N using a bit-serial Montgomery multiplier.
// K LSBs of each new state are packed into OUT_W-bit words and sent out on a valid/ready stream.
//
// state | meaning
// IDLE  | waiting for run with a valid loaded config
// SQ    | M cycles of MM(x, x)
// SQF   | final subtract of the square pass, result seeds the conversion pass
// CV    | M cycles of MM(t, C)
// CVF   | final subtract, x takes the new state
// PACK  | append x[K-1:0] to the partial word
// HOLD  | word presented, waiting for out_ready
module bbs_stream_gen #(
   parameter int M     = 16,
   parameter int K     = 1,
   parameter int OUT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   bbs_stream_gen_if.slave  bus
);

   localparam int NW = OUT_W / K;
   localparam int CW = $clog2(NW + 1);
   localparam int BW = (M > 1) ? $clog2(M) : 1;

   typedef enum logic [2:0] {IDLE, SQ, SQF, CV, CVF, PACK, HOLD} state_t;

   state_t           state_q;
   logic [M-1:0]     x_q, n_q, c_q, a_q;
   logic [M+2:0]     acc_q;
   logic [BW-1:0]    bit_q;
   logic [CW-1:0]    cnt_q;
   logic [OUT_W-1:0] pk_q, dout_q;
   logic             vld_q, err_q, ld_q;

   logic [M-1:0]     b_op;
   logic [M+2:0]     t_sum, u_sum, n_ext;
   logic [M-1:0]     red;
   logic [OUT_W-1:0] pk_new;
   logic             cfg_ok, last;

   assign b_op  = (state_q == CV) ? c_q : x_q;
   assign n_ext = {3'b000, n_q};
   assign t_sum = acc_q + (a_q[0] ? {3'b000, b_op} : '0);
   assign u_sum = t_sum + (t_sum[0] ? n_ext : '0);
   // Result of a pass is below 2N, and after one subtract it fits in M bits.
   assign red   = (acc_q >= n_ext) ? (acc_q[M-1:0] - n_q) : acc_q[M-1:0];

   assign cfg_ok = bus.n[0] && (bus.seed > {{(M-1){1'b0}}, 1'b1}) && (bus.seed < bus.n);
   assign last   = (cnt_q == CW'(NW - 1));

   always_comb begin
      pk_new = pk_q;
      for (int i = 0; i < NW; i++) begin
         if (cnt_q == CW'(i)) pk_new[i*K +: K] = x_q[K-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         n_q     <= '0;
         c_q     <= '0;
         a_q     <= '0;
         acc_q   <= '0;
         bit_q   <= '0;
         cnt_q   <= '0;
         pk_q    <= '0;
         dout_q  <= '0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
         ld_q    <= 1'b0;
      end else if (bus.load) begin
         x_q     <= bus.seed;
         n_q     <= bus.n;
         c_q     <= bus.c;
         err_q   <= !cfg_ok;
         ld_q    <= cfg_ok;
         state_q <= IDLE;
         vld_q   <= 1'b0;
         cnt_q   <= '0;
         pk_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.run && !err_q && ld_q) begin
                  state_q <= SQ;
                  acc_q   <= '0;
                  a_q     <= x_q;
                  bit_q   <= BW'(M - 1);
               end
            end
            SQ, CV: begin
               acc_q <= u_sum >> 1;
               a_q   <= a_q >> 1;
               if (bit_q == '0) state_q <= (state_q == SQ) ? SQF : CVF;
               else             bit_q   <= bit_q - 1'b1;
            end
            SQF: begin
               a_q     <= red;
               acc_q   <= '0;
               bit_q   <= BW'(M - 1);
               state_q <= CV;
            end
            CVF: begin
               x_q     <= red;
               state_q <= PACK;
            end
            PACK: begin
               if (last) begin
                  dout_q  <= pk_new;
                  vld_q   <= 1'b1;
                  cnt_q   <= '0;
                  pk_q    <= '0;
                  state_q <= HOLD;
               end else begin
                  pk_q  <= pk_new;
                  cnt_q <= cnt_q + 1'b1;
                  if (bus.run) begin
                     state_q <= SQ;
                     acc_q   <= '0;
                     a_q     <= x_q;
                     bit_q   <= BW'(M - 1);
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  vld_q <= 1'b0;
                  if (bus.run) begin
                     state_q <= SQ;
                     acc_q   <= '0;
                     a_q     <= x_q;
                     bit_q   <= BW'(M - 1);
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.out_valid = vld_q;
   assign bus.out_data  = dout_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.err       = err_q;

endmodule

// File: tb/tb_bbs_stream_gen.sv
// Scoreboard bench: two generators (K=1 and K=2) share one stimulus stream and are
// checked against a plain-arithmetic BBS model.
module tb_bbs_stream_gen;
   localparam int M = 16;
   localparam int OUT_W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   bbs_stream_gen_if #(.M(M), .OUT_W(OUT_W)) b1 ();
   bbs_stream_gen_if #(.M(M), .OUT_W(OUT_W)) b2 ();

   bbs_stream_gen #(.M(M), .K(1), .OUT_W(OUT_W)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   bbs_stream_gen #(.M(M), .K(2), .OUT_W(OUT_W)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

   assign b2.load      = b1.load;
   assign b2.seed      = b1.seed;
   assign b2.n         = b1.n;
   assign b2.c         = b1.c;
   assign b2.run       = b1.run;
   assign b2.out_ready = b1.out_ready;

   int vec = 0, mis = 0;
   int rx1 = 0, rx2 = 0;
   logic [7:0] q1[$], q2[$];
   logic [7:0] log1[$], log2[$];
   int cyc1[$];

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      vec++;
      if (act !== exp) begin
         mis++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endfunction

   // Reference: iterate x = x*x mod n, take the low k bits of each new x, first bits at LSB.
   task automatic model_push(input logic [15:0] s, input logic [15:0] n);
      longint x;
      logic [7:0] w;
      q1.delete(); q2.delete();
      x = s;
      for (int wi = 0; wi < 16; wi++) begin
         w = 0;
         for (int i = 0; i < 8; i++) begin
            x = (x * x) % n;
            w = w | 8'((x % 2) << i);
         end
         q1.push_back(w);
      end
      x = s;
      for (int wi = 0; wi < 16; wi++) begin
         w = 0;
         for (int i = 0; i < 4; i++) begin
            x = (x * x) % n;
            w = w | 8'((x % 4) << (2 * i));
         end
         q2.push_back(w);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && b1.out_valid && b1.out_ready && !b1.load) begin
         if (q1.size() == 0) begin
            vec++; mis++;
            $display("FAIL u1_word: got %0h, expected no word", b1.out_data);
         end else begin
            chk("u1_word", b1.out_data, q1.pop_front());
         end
         rx1++;
         log1.push_back(b1.out_data);
         cyc1.push_back(cyc);
      end
   end

   always @(negedge clk) begin
      if (rst_n && b2.out_valid && b2.out_ready && !b2.load) begin
         if (q2.size() == 0) begin
            vec++; mis++;
            $display("FAIL u2_word: got %0h, expected no word", b2.out_data);
         end else begin
            chk("u2_word", b2.out_data, q2.pop_front());
         end
         rx2++;
         log2.push_back(b2.out_data);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_load(input logic [15:0] s, input logic [15:0] n, input logic [15:0] c, input bit good);
      b1.seed = s; b1.n = n; b1.c = c; b1.load = 1'b1;
      if (good) model_push(s, n);
      else begin q1.delete(); q2.delete(); end
      log1.delete(); log2.delete(); cyc1.delete();
      tick(1);
      b1.load = 1'b0;
   endtask

   task automatic wait_rx1(input int target, input int budget, input string nm);
      int k = 0;
      while (rx1 < target && k < budget) begin tick(1); k++; end
      chk(nm, (rx1 >= target), 1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, r0, t;
      logic [7:0] d0;
      bit ok;
      logic [15:0] rn, rs, rc;

      b1.load = 0; b1.seed = 0; b1.n = 0; b1.c = 0; b1.run = 0; b1.out_ready = 0;
      #2;
      chk("rst_valid", b1.out_valid, 0);
      chk("rst_data", b1.out_data, 0);
      chk("rst_busy", b1.busy, 0);
      chk("rst_err", b1.err, 0);
      #20 rst_n = 1'b1;
      tick(2);

      // Nominal run: latency, first words, throughput
      do_load(16'd3, 16'd209, 16'd158, 1);
      chk("load_err", b1.err, 0);
      b1.run = 1; b1.out_ready = 1;
      tick(1);
      chk("busy_sq", b1.busy, 1);
      n = 0;
      while (!b1.out_valid && n < 400) begin tick(1); n++; end
      chk("latency", n, 280);
      chk("first_word", b1.out_data, 8'h83);
      wait_rx1(2, 400, "second_word_timeout");
      chk("period", (cyc1.size() >= 2) ? (cyc1[1] - cyc1[0]) : -1, 281);
      chk("u2_first", (log2.size() > 0) ? log2[0] : 16'hDEAD, 8'h25);

      // Back-pressure
      b1.out_ready = 0;
      do_load(16'd3, 16'd209, 16'd158, 1);
      n = 0;
      while (!b1.out_valid && n < 400) begin tick(1); n++; end
      chk("bp_valid", b1.out_valid, 1);
      chk("bp_word", b1.out_data, 8'h83);
      d0 = b1.out_data; ok = 1;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         if (b1.out_data !== d0 || b1.busy !== 1'b1 || b1.out_valid !== 1'b1) ok = 0;
      end
      chk("bp_hold", ok, 1);
      b1.out_ready = 1;
      r0 = rx1;
      wait_rx1(r0 + 2, 800, "bp_resume_timeout");

      // Bad modulus, then recovery
      b1.run = 0;
      do_load(16'd3, 16'd208, 16'd158, 0);
      chk("err_set", b1.err, 1);
      b1.run = 1;
      tick(100);
      chk("err_busy", b1.busy, 0);
      chk("err_valid", b1.out_valid, 0);
      do_load(16'd3, 16'd209, 16'd158, 1);
      chk("err_clear", b1.err, 0);
      r0 = rx1;
      wait_rx1(r0 + 1, 400, "reload_timeout");
      chk("reload_word", (log1.size() > 0) ? log1[0] : 16'hDEAD, 8'h83);

      // Load mid-CV of the fourth iteration, together with out_ready
      do_load(16'd3, 16'd209, 16'd158, 1);
      tick(3 * 35 + 20);
      do_load(16'd3, 16'd209, 16'd158, 1);
      chk("abort_valid", b1.out_valid, 0);
      chk("abort_busy", b1.busy, 0);
      r0 = rx1;
      wait_rx1(r0 + 1, 400, "abort_timeout");
      chk("abort_word", (log1.size() > 0) ? log1[0] : 16'hDEAD, 8'h83);

      // Random configurations with random run/ready
      for (int it = 0; it < 4; it++) begin
         rn = 16'($urandom_range(1, 32767) * 2 + 1);
         rs = 16'($urandom_range(2, rn - 1));
         rc = 16'(64'h1_0000_0000 % rn);
         do_load(rs, rn, rc, 1);
         chk("rand_err", b1.err, 0);
         r0 = rx1; t = 0;
         while (rx1 < r0 + 3 && t < 6000) begin
            b1.run = ($urandom_range(0, 3) != 0);
            b1.out_ready = $urandom_range(0, 1);
            tick(1); t++;
         end
         chk("rand_timeout", (rx1 >= r0 + 3), 1);
      end

      // Asynchronous reset mid-SQ
      b1.out_ready = 1; b1.run = 1;
      do_load(16'd3, 16'd209, 16'd158, 1);
      tick(5);
      b1.out_ready = $urandom_range(0, 1);
      b1.seed = 16'($urandom);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", b1.out_valid, 0);
      chk("arst_data", b1.out_data, 0);
      chk("arst_busy", b1.busy, 0);
      chk("arst_busy2", b2.busy, 0);
      chk("arst_err", b1.err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end
endmodule
